// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter that shares the single leaf-to-BFT packet output among the user output
// streams. Each accepted word goes out in a packet tagged with its destination and a per-port sequence number.
module leaf_out_arbiter #(
  parameter int unsigned NUM_OUT_PORTS         = 4,
  parameter int unsigned PAYLOAD_BITS          = 32,
  parameter int unsigned PACKET_BITS           = 49,
  parameter int unsigned NUM_LEAF_BITS         = 5,
  parameter int unsigned NUM_PORT_BITS         = 4,
  parameter int unsigned SEQ_BITS              = 7,
  parameter int unsigned CREDIT_BITS           = 8,
  parameter int unsigned CREDIT_INIT           = 64,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64,
  localparam int unsigned SEL_BITS = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user2arb,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user2arb,
  output logic [NUM_OUT_PORTS-1:0]                ack_arb2user,
  input  logic                                    cfg_we,
  input  logic [SEL_BITS-1:0]                     cfg_sel,
  input  logic [NUM_LEAF_BITS-1:0]                cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]                cfg_port,
  input  logic                                    credit_upd,
  input  logic [SEL_BITS-1:0]                     credit_sel,
  output logic [PACKET_BITS-1:0]                  pkt_out,
  output logic                                    pkt_vld,
  input  logic                                    pkt_rdy,
  input  logic                                    resend
);

  localparam logic [CREDIT_BITS:0] CREDIT_MAX = {1'b0, {CREDIT_BITS{1'b1}}};
  localparam logic [CREDIT_BITS:0] CREDIT_ADD = (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE);
  localparam logic [SEL_BITS:0]    PORTS_W    = (SEL_BITS+1)'(NUM_OUT_PORTS);

  logic [NUM_OUT_PORTS-1:0]  cfg_valid_q, cfg_valid_d;
  logic [NUM_LEAF_BITS-1:0]  leaf_q   [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0]  leaf_d   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]  port_q   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]  port_d   [NUM_OUT_PORTS];
  logic [SEQ_BITS-1:0]       seq_q    [NUM_OUT_PORTS];
  logic [SEQ_BITS-1:0]       seq_d    [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]    credit_q [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]    credit_d [NUM_OUT_PORTS];
  logic [SEL_BITS-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PACKET_BITS-1:0]    pkt_out_q, pkt_out_d;
  logic                      pkt_vld_q, pkt_vld_d;

  logic [PAYLOAD_BITS-1:0]   word_s [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0]  eligible_s;
  logic                      free_s;
  logic                      grant_vld_s;
  logic [SEL_BITS-1:0]       grant_idx_s;
  logic [PACKET_BITS-1:0]    packet_s;

  assign pkt_out = pkt_out_q;
  assign pkt_vld = pkt_vld_q;
  assign free_s  = !pkt_vld_q || pkt_rdy;

  // Eligibility and round-robin search starting at rr_ptr; ack is the one-hot grant.
  always_comb begin
    logic [SEL_BITS:0] idx_v;
    idx_v        = '0;
    grant_vld_s  = 1'b0;
    grant_idx_s  = '0;
    ack_arb2user = '0;
    for (int i = 0; i < int'(NUM_OUT_PORTS); i++) begin
      word_s[i]     = din_user2arb[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      eligible_s[i] = vld_user2arb[i] && cfg_valid_q[i] && (credit_q[i] != '0);
    end
    if (free_s && !resend) begin
      for (int k = 0; k < int'(NUM_OUT_PORTS); k++) begin
        idx_v = {1'b0, rr_ptr_q} + (SEL_BITS+1)'(k);
        if (idx_v >= PORTS_W) begin
          idx_v = idx_v - PORTS_W;
        end else begin
          idx_v = idx_v;
        end
        if (!grant_vld_s && eligible_s[idx_v[SEL_BITS-1:0]]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = idx_v[SEL_BITS-1:0];
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end else begin
      grant_vld_s = 1'b0;
    end
    if (grant_vld_s) begin
      ack_arb2user[grant_idx_s] = 1'b1;
    end else begin
      ack_arb2user = '0;
    end
  end

  // Packet assembly uses the destination registered before any same-cycle config write.
  assign packet_s = {1'b1, leaf_q[grant_idx_s], port_q[grant_idx_s], seq_q[grant_idx_s],
                     word_s[grant_idx_s]};

  // Next-state for per-port config, sequence and credit, plus output register and pointer.
  always_comb begin
    logic [CREDIT_BITS:0] sum_v;
    sum_v       = '0;
    cfg_valid_d = cfg_valid_q;
    leaf_d      = leaf_q;
    port_d      = port_q;
    seq_d       = seq_q;
    credit_d    = credit_q;
    rr_ptr_d    = rr_ptr_q;
    pkt_out_d   = pkt_out_q;
    pkt_vld_d   = pkt_vld_q;
    for (int i = 0; i < int'(NUM_OUT_PORTS); i++) begin
      if (cfg_we && (cfg_sel == SEL_BITS'(i))) begin
        cfg_valid_d[i] = 1'b1;
        leaf_d[i]      = cfg_leaf;
        port_d[i]      = cfg_port;
      end else begin
        cfg_valid_d[i] = cfg_valid_q[i];
      end
      // A grant implies credit >= 1, so the decrement cannot underflow.
      sum_v = {1'b0, credit_q[i]};
      if (grant_vld_s && (grant_idx_s == SEL_BITS'(i))) begin
        sum_v    = sum_v - {{CREDIT_BITS{1'b0}}, 1'b1};
        seq_d[i] = seq_q[i] + {{(SEQ_BITS-1){1'b0}}, 1'b1};
      end else begin
        seq_d[i] = seq_q[i];
      end
      if (credit_upd && (credit_sel == SEL_BITS'(i))) begin
        sum_v = (sum_v > CREDIT_MAX - CREDIT_ADD) ? CREDIT_MAX : sum_v + CREDIT_ADD;
      end else begin
        sum_v = sum_v;
      end
      credit_d[i] = sum_v[CREDIT_BITS-1:0];
    end
    if (!resend && free_s) begin
      pkt_vld_d = grant_vld_s;
      if (grant_vld_s) begin
        pkt_out_d = packet_s;
        rr_ptr_d  = (grant_idx_s == SEL_BITS'(NUM_OUT_PORTS - 1)) ? '0
                    : grant_idx_s + {{(SEL_BITS-1){1'b0}}, 1'b1};
      end else begin
        pkt_out_d = pkt_out_q;
      end
    end else begin
      pkt_vld_d = pkt_vld_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_valid_q <= '0;
      rr_ptr_q    <= '0;
      pkt_out_q   <= '0;
      pkt_vld_q   <= 1'b0;
      for (int i = 0; i < int'(NUM_OUT_PORTS); i++) begin
        leaf_q[i]   <= '0;
        port_q[i]   <= '0;
        seq_q[i]    <= '0;
        credit_q[i] <= CREDIT_BITS'(CREDIT_INIT);
      end
    end else begin
      cfg_valid_q <= cfg_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      pkt_out_q   <= pkt_out_d;
      pkt_vld_q   <= pkt_vld_d;
      for (int i = 0; i < int'(NUM_OUT_PORTS); i++) begin
        leaf_q[i]   <= leaf_d[i];
        port_q[i]   <= port_d[i];
        seq_q[i]    <= seq_d[i];
        credit_q[i] <= credit_d[i];
      end
    end
  end

endmodule

// File: doc/leaf_out_arbiter.md
Name: leaf_out_arbiter

Overview:
- Shares the single leaf-to-BFT packet output among the user kernel's NUM_OUT_PORTS output streams.
- Round-robin arbitration, gated by per-port destination configuration and per-port credits.
- Wraps each 32-bit user word into a 49-bit BFT packet: destination leaf/port, 7-bit per-port sequence number, payload.
- Sits between the user-side output handshakes and the packet output toward the BFT, in the 400 MHz domain.

Parameters:
- NUM_OUT_PORTS, 4, number of user output streams arbitrated
- PAYLOAD_BITS, 32, user word width
- PACKET_BITS, 49, BFT packet width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- SEQ_BITS, 7, per-port sequence field width
- CREDIT_BITS, 8, per-port credit counter width
- CREDIT_INIT, 64, credit value loaded at reset
- FREESPACE_UPDATE_SIZE, 64, credits added per credit-update pulse

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- din_user2arb  in  NUM_OUT_PORTS*PAYLOAD_BITS  user words; port i occupies bits [32i+31:32i]
- vld_user2arb  in  NUM_OUT_PORTS  per-port word valid
- ack_arb2user  out  NUM_OUT_PORTS  per-port one-cycle accept pulse
- cfg_we  in  1  destination config write strobe
- cfg_sel  in  2  source port being configured
- cfg_leaf  in  NUM_LEAF_BITS  destination leaf
- cfg_port  in  NUM_PORT_BITS  destination port
- credit_upd  in  1  credit return pulse
- credit_sel  in  2  source port receiving credits
- pkt_out  out  PACKET_BITS  packet toward BFT
- pkt_vld  out  1  pkt_out valid
- pkt_rdy  in  1  BFT side accepts pkt_out this cycle
- resend  in  1  freeze request from the leaf shell

Behaviour:
- Reset (reset=0, async): ack_arb2user=0, pkt_out=0, pkt_vld=0, rr_ptr=0.
  - All cfg_valid=0, dest fields=0, seq=0, credit=CREDIT_INIT.
- Packet format:
  - [48]=1 (valid)
  - [47:43]=dest leaf
  - [42:39]=dest port
  - [38:32]=seq
  - [31:0]=payload
- Eligibility: port i is eligible when vld_user2arb[i] && cfg_valid[i] && credit[i]!=0.
- Output register state: "free" = !pkt_vld || pkt_rdy.
- Grant: when free && !resend && any port eligible, grant the first eligible port searching rr_ptr, rr_ptr+1, … mod NUM_OUT_PORTS.
  - ack_arb2user[g]=1 combinationally in the grant cycle; never more than one ack bit high.
  - Next edge: pkt_out loads the packet, pkt_vld=1, seq[g]++ (wraps 127->0), credit[g]--, rr_ptr=g+1 mod NUM_OUT_PORTS.
- Latency: vld to ack is 0 cycles when free; ack to pkt_vld is 1 cycle.
  - Sustained throughput is 1 packet/cycle while pkt_rdy=1.
- Hold: if pkt_vld && !pkt_rdy, pkt_out and pkt_vld are held unchanged and no ack is issued.
- Drain: if pkt_rdy && no grant, pkt_vld goes 0 next cycle; pkt_out keeps its last value.
- resend=1: no grants and pkt_out/pkt_vld held. Returning to resend=0 resumes arbitration the next cycle with rr_ptr unchanged.
- Config write:
  - cfg_we latches dest fields for cfg_sel and sets cfg_valid, next edge.
  - Does not alter a packet already in pkt_out.
  - A write coinciding with a grant on the same port: the grant uses the old dest.
- Credits:
  - credit_upd adds FREESPACE_UPDATE_SIZE, saturating at 2^CREDIT_BITS-1.
  - Grant and update on the same port in the same cycle: net +FREESPACE_UPDATE_SIZE-1, still saturating.
  - credit=0: port ineligible; its vld is ignored with no ack.
- Arithmetic: seq is modulo 2^SEQ_BITS; credit is never negative.
- Reset mid-packet: an in-flight pkt_vld drops immediately; sequences restart at 0.

Test Plan:
- Single port: reset; cfg port0 -> leaf 3, port 2; vld0 with 0xDEADBEEF, pkt_rdy=1 -> ack0 in that cycle; next cycle pkt_vld=1, pkt_out=1_00011_0010_0000000_DEADBEEF.
- Fairness: all 4 ports configured and continuously valid, pkt_rdy=1 -> acks in order 0,1,2,3,0,1… with one packet per cycle; port 1 drops vld -> order becomes 0,2,3,0.
- Backpressure: pkt_rdy=0 for 5 cycles with 3 ports valid -> pkt_out is stable, no acks; pkt_rdy=1 -> the next grant is the port after the held one.
- Credits: port0 with CREDIT_INIT=64 sends 64 words -> 65th vld gets no ack; credit_upd for port0 -> ack resumes next cycle. Saturation: at credit 250, one update -> 255.
- Sequence wrap: 130 packets on port2 (with periodic credit updates) -> seq field runs 0..127 then 0,1.
- resend/reset: resend=1 during traffic -> no acks, pkt_out frozen; release -> resumes. Asserting reset mid-stream -> pkt_vld=0 immediately; after release, credit=64, seq=0, cfg_valid=0 (no acks until reconfigured).
